sc_level_speedtimer: RTL and testbench



---
 rtl/sc_level_speedtimer.sv | 135 +++++++++++++
 tb/tb_sc_level_speedtimer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_level_speedtimer.sv
// Level-scaled active-low move tick for the lane and obstacle movers.
// Optional pause input is built when SC_LEVELSPEED_PAUSE_EN is defined.
module sc_level_speedtimer #(
  parameter int CURRENTSTATE_DATAWIDTH = 2,
  parameter int LEVELCOUNTER_DATAWIDTH = 3,
  parameter int PERIOD_DATAWIDTH       = 26,
  parameter int BASE_PERIOD            = 25000000,
  parameter int PERIOD_STEP            = 5000000,
  parameter int MIN_PERIOD             = 5000000
) (
  input  logic SC_LEVELCOUNTER_CLOCK_50,
  input  logic SC_LEVELCOUNTER_RESET_InHigh,
  input  logic [CURRENTSTATE_DATAWIDTH-1:0]
               SC_LEVELSPEED_CurrentState_InBus,
  input  logic [LEVELCOUNTER_DATAWIDTH-1:0]
               SC_LEVELSPEED_Level_InBus,
`ifdef SC_LEVELSPEED_PAUSE_EN
  input  logic SC_LEVELSPEED_Pause_InLow,
`endif
  output logic SC_LEVELSPEED_Tick_OutLow,
  output logic [PERIOD_DATAWIDTH-1:0]
               SC_LEVELSPEED_Period_OutBus,
  output logic SC_LEVELSPEED_Running_Out
);

  localparam int CW = CURRENTSTATE_DATAWIDTH;
  localparam int LW = LEVELCOUNTER_DATAWIDTH;
  localparam int PW = PERIOD_DATAWIDTH;
  localparam int XW = PW + LW;

  localparam logic [XW-1:0] STEP_X =
    XW'(PERIOD_STEP);
  localparam logic [XW-1:0] SPAN_X =
    XW'(BASE_PERIOD - MIN_PERIOD);
  localparam logic [PW-1:0] BASE_P =
    PW'(BASE_PERIOD);
  localparam logic [PW-1:0] MIN_P =
    PW'(MIN_PERIOD);
  localparam logic [PW-1:0] ONE_P = PW'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FREEZE
  } state_t;

  logic          clk;
  logic          rst;
  logic [XW-1:0] scaled;
  logic [PW-1:0] period_calc;
  logic [PW-1:0] cnt;
  logic [PW-1:0] period;
  logic          tick;
  logic          running;
  logic          hold;
  logic          is_run;
  logic          is_frz;
  state_t        state;

  assign clk = SC_LEVELCOUNTER_CLOCK_50;
  assign rst = SC_LEVELCOUNTER_RESET_InHigh;

`ifdef SC_LEVELSPEED_PAUSE_EN
  assign hold = ~SC_LEVELSPEED_Pause_InLow;
`else
  assign hold = 1'b0;
`endif

  // Wide product so the clamp compare never sees a wrapped value.
  assign scaled = XW'(SC_LEVELSPEED_Level_InBus) * STEP_X;

  always_comb begin
    period_calc = MIN_P;
    if (scaled < SPAN_X)
      period_calc = BASE_P - PW'(scaled);
  end

  assign is_run =
    (SC_LEVELSPEED_CurrentState_InBus == CW'(1));
  assign is_frz =
    (SC_LEVELSPEED_CurrentState_InBus == CW'(2));

  always_comb begin
    state = IDLE;
    unique case (1'b1)
      is_run:  state = RUN;
      is_frz:  state = FREEZE;
      default: state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      tick    <= 1'b1;
      period  <= BASE_P;
      running <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          period <= period_calc;
          if (hold) begin
            tick    <= 1'b1;
            running <= 1'b0;
          end else begin
            running <= 1'b1;
            // >= so a level shrink below cnt fires at once.
            if (cnt >= period - ONE_P) begin
              cnt  <= '0;
              tick <= 1'b0;
            end else begin
              cnt  <= cnt + ONE_P;
              tick <= 1'b1;
            end
          end
        end
        FREEZE: begin
          tick    <= 1'b1;
          running <= 1'b0;
        end
        default: begin
          cnt     <= '0;
          tick    <= 1'b1;
          running <= 1'b0;
          period  <= BASE_P;
        end
      endcase
    end
  end

  assign SC_LEVELSPEED_Tick_OutLow   = tick;
  assign SC_LEVELSPEED_Period_OutBus = period;
  assign SC_LEVELSPEED_Running_Out   = running;

endmodule

// File: tb/tb_sc_level_speedtimer.sv
// Bench for sc_level_speedtimer: expected tick cycles are queued
// when stimulus is driven and matched against observed ticks.
module tb_sc_level_speedtimer;

  logic        clk;
  logic        rst;
  logic [1:0]  cur_state;
  logic [2:0]  level;
`ifdef SC_LEVELSPEED_PAUSE_EN
  logic        pause_n;
`endif
  logic        tick;
  logic [25:0] period;
  logic        running;

  int n_chk;
  int n_fail;
  int cyc;
  int exp_q[$];
  int mon_e;
  int c0;
  int c1;

  sc_level_speedtimer #(
    .CURRENTSTATE_DATAWIDTH(2),
    .LEVELCOUNTER_DATAWIDTH(3),
    .PERIOD_DATAWIDTH(26),
    .BASE_PERIOD(20),
    .PERIOD_STEP(4),
    .MIN_PERIOD(8)
  ) dut (
    .SC_LEVELCOUNTER_CLOCK_50(clk),
    .SC_LEVELCOUNTER_RESET_InHigh(rst),
    .SC_LEVELSPEED_CurrentState_InBus(cur_state),
    .SC_LEVELSPEED_Level_InBus(level),
`ifdef SC_LEVELSPEED_PAUSE_EN
    .SC_LEVELSPEED_Pause_InLow(pause_n),
`endif
    .SC_LEVELSPEED_Tick_OutLow(tick),
    .SC_LEVELSPEED_Period_OutBus(period),
    .SC_LEVELSPEED_Running_Out(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic go_idle();
    cur_state = 2'd0;
    run_to(cyc + 2);
    chk("idle_running", 32'(running), 32'd0);
    chk("idle_period", 32'(period), 32'd20);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Tick monitor: each low tick consumes the oldest expected cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (tick === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("tick_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tick_cycle", 32'(cyc), 32'(mon_e));
        end
      end
      if (exp_q.size() != 0 && cyc > exp_q[0]) begin
        mon_e = exp_q.pop_front();
        chk("tick_missing", 32'(cyc), 32'(mon_e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    cur_state = 2'd0;
    level     = 3'd0;
`ifdef SC_LEVELSPEED_PAUSE_EN
    pause_n   = 1'b1;
`endif
    repeat (3) @(negedge clk);
    chk("rst_tick", 32'(tick), 32'd1);
    chk("rst_period", 32'(period), 32'd20);
    chk("rst_running", 32'(running), 32'd0);
    rst = 1'b0;
    run_to(cyc + 2);

    // Level 0: ticks 20, 40, 60 clocks after RUN entry.
    c0 = cyc;
    cur_state = 2'd1;
    exp_q.push_back(c0 + 20);
    exp_q.push_back(c0 + 40);
    exp_q.push_back(c0 + 60);
    run_to(c0 + 3);
    chk("l0_running", 32'(running), 32'd1);
    chk("l0_period", 32'(period), 32'd20);
    run_to(c0 + 65);
    go_idle();

    // Level 2: period 12; then level 5 clamps to 8.
    c0 = cyc;
    level = 3'd2;
    cur_state = 2'd1;
    exp_q.push_back(c0 + 12);
    exp_q.push_back(c0 + 24);
    exp_q.push_back(c0 + 36);
    run_to(c0 + 40);
    chk("l2_period", 32'(period), 32'd12);
    c1 = cyc;
    level = 3'd5;
    exp_q.push_back(c1 + 4);
    exp_q.push_back(c1 + 12);
    exp_q.push_back(c1 + 20);
    run_to(c1 + 1);
    chk("l5_period", 32'(period), 32'd8);
    run_to(c1 + 22);
    go_idle();

    // Shrink below the count: level 0 at Cnt=15, then level 3.
    level = 3'd0;
    c0 = cyc;
    cur_state = 2'd1;
    run_to(c0 + 15);
    level = 3'd3;
    exp_q.push_back(c0 + 17);
    exp_q.push_back(c0 + 25);
    exp_q.push_back(c0 + 33);
    run_to(c0 + 16);
    chk("l3_period", 32'(period), 32'd8);
    run_to(c0 + 35);
    go_idle();

    // Freeze at Cnt=7 for 50 clocks, then resume.
    level = 3'd0;
    c0 = cyc;
    cur_state = 2'd1;
    run_to(c0 + 7);
    cur_state = 2'd2;
    run_to(c0 + 57);
    chk("frz_running", 32'(running), 32'd0);
    chk("frz_tick", 32'(tick), 32'd1);
    chk("frz_period", 32'(period), 32'd20);
    c1 = cyc;
    cur_state = 2'd1;
    exp_q.push_back(c1 + 13);
    run_to(c1 + 15);
    chk("res_running", 32'(running), 32'd1);
    go_idle();

    // Cnt cleared by IDLE; reset at Cnt=10.
    c0 = cyc;
    cur_state = 2'd1;
    exp_q.push_back(c0 + 20);
    run_to(c0 + 10);
    rst = 1'b1;
    #1;
    chk("mid_rst_tick", 32'(tick), 32'd1);
    chk("mid_rst_period", 32'(period), 32'd20);
    chk("mid_rst_running", 32'(running), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    c1 = cyc;
    rst = 1'b0;
    exp_q.push_back(c1 + 20);
    exp_q.push_back(c1 + 40);
    run_to(c1 + 42);
    go_idle();

`ifdef SC_LEVELSPEED_PAUSE_EN
    // Pause 30 clocks at Cnt=5.
    c0 = cyc;
    cur_state = 2'd1;
    run_to(c0 + 5);
    pause_n = 1'b0;
    run_to(c0 + 35);
    chk("pause_running", 32'(running), 32'd0);
    chk("pause_period", 32'(period), 32'd20);
    c1 = cyc;
    pause_n = 1'b1;
    exp_q.push_back(c1 + 15);
    run_to(c1 + 17);
    chk("unpause_running", 32'(running), 32'd1);
    go_idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
